// File: rtl/digit_packer.sv
// digit_packer: rebuilds a W-bit two's-complement value from NDIG packed
// 4-bit digits, most-significant digit first, in radix 10 (packed BCD with an
// optional 4'hF sign nibble on top) or radix 16 (raw hex). Uses a start/busy/done
// handshake and processes one digit per cycle.
module digit_packer #(
   parameter int NDIG = 8,
   parameter int W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cs10,
   input  logic         cs16,
   input  logic [W-1:0] digits_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] bin_out,
   output logic [4:0]   radix,
   output logic         err
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [W-1:0]  digits_r;
   logic [W-1:0]  acc_r;
   logic [IW-1:0] idx_r;
   logic          dec_r;
   logic          neg_r;
   logic          bad_r;
   logic          busy_r;
   logic          done_r;
   logic [W-1:0]  bin_r;
   logic [4:0]    radix_r;
   logic          err_r;

   logic          accept_s;
   logic          sign_pos_s;
   logic [3:0]    digit_raw_s;
   logic [3:0]    digit_s;
   logic          bad_digit_s;
   logic [W-1:0]  acc_next_s;
   logic [W-1:0]  final_s;

   // A decimal digit above 9 is invalid unless it is the sign nibble on top.
   function automatic logic is_bad_dec(input logic [3:0] nib, input logic sign_slot);
      logic bad;
      if (sign_slot && (nib == 4'hF)) begin
         bad = 1'b0;
      end else begin
         bad = (nib > 4'd9);
      end
      return bad;
   endfunction

   // Handshake decode, current-digit selection, multiply-accumulate and result.
   always_comb begin
      accept_s    = 1'b0;
      sign_pos_s  = 1'b0;
      digit_raw_s = 4'h0;
      digit_s     = 4'h0;
      bad_digit_s = 1'b0;
      acc_next_s  = {W{1'b0}};
      final_s     = {W{1'b0}};

      accept_s    = (state_r == ST_IDLE) && start && (cs10 ^ cs16);
      sign_pos_s  = (idx_r == IDX_TOP);
      digit_raw_s = digits_r[{idx_r, 2'b00} +: 4];

      if (dec_r && sign_pos_s && neg_r) begin
         digit_s = 4'h0;
      end else begin
         digit_s = digit_raw_s;
      end

      if (dec_r) begin
         bad_digit_s = is_bad_dec(digit_raw_s, sign_pos_s);
         acc_next_s  = (acc_r << 3) + (acc_r << 1) + W'(digit_s);
      end else begin
         bad_digit_s = 1'b0;
         acc_next_s  = (acc_r << 4) + W'(digit_s);
      end

      if (bad_r) begin
         final_s = {W{1'b0}};
      end else if (neg_r) begin
         final_s = -acc_r;
      end else begin
         final_s = acc_r;
      end
   end

   // Next-state logic for IDLE -> ACC -> FIN -> IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_ACC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (idx_r == {IW{1'b0}}) begin
               state_s = ST_FIN;
            end else begin
               state_s = ST_ACC;
            end
         end
         ST_FIN:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_r <= {W{1'b0}};
         acc_r    <= {W{1'b0}};
         idx_r    <= {IW{1'b0}};
         dec_r    <= 1'b0;
         neg_r    <= 1'b0;
         bad_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         bin_r    <= {W{1'b0}};
         radix_r  <= 5'd0;
         err_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  digits_r <= digits_in;
                  acc_r    <= {W{1'b0}};
                  idx_r    <= IDX_TOP;
                  dec_r    <= cs10;
                  neg_r    <= cs10 && (digits_in[W-1 -: 4] == 4'hF);
                  bad_r    <= 1'b0;
                  busy_r   <= 1'b1;
                  radix_r  <= cs10 ? 5'd10 : 5'd16;
               end else begin
                  // radix stays visible through the done cycle, then drops
                  radix_r  <= 5'd0;
               end
            end
            ST_ACC: begin
               acc_r <= acc_next_s;
               bad_r <= bad_r | bad_digit_s;
               idx_r <= idx_r - {{(IW-1){1'b0}}, 1'b1};
            end
            ST_FIN: begin
               bin_r  <= final_s;
               err_r  <= bad_r;
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign bin_out = bin_r;
   assign radix   = radix_r;
   assign err     = err_r;

endmodule

// File: tb/tb_digit_packer.sv
// Bench for digit_packer: a cycle-level reference model computes the expected
// handshake and result from plain digit arithmetic; directed cases pin literals.
module tb_digit_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cs10 = 1'b0;
   logic        cs16 = 1'b0;
   logic [31:0] digits_in = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] bin_out;
   logic [4:0]  radix;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // reference model state
   bit          m_valid = 1'b0;
   int          m_cnt = 0;
   logic        m_busy, m_done, m_err, p_err;
   logic [31:0] m_bin, p_bin;
   logic [4:0]  m_radix;

   always #5 clk = ~clk;

   digit_packer #(.NDIG(8), .W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .cs10(cs10), .cs16(cs16),
      .digits_in(digits_in), .busy(busy), .done(done), .bin_out(bin_out),
      .radix(radix), .err(err)
   );

   // Returns {err, value} computed digit by digit with integer arithmetic.
   function automatic logic [32:0] ref_conv(input logic [31:0] d, input logic dec);
      longint mag = 0;
      logic   neg, bad;
      logic [3:0]  nib;
      logic [31:0] v;
      if (!dec) return {1'b0, d};
      neg = (d[31:28] == 4'hF);
      bad = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         nib = d[i*4 +: 4];
         if (i == 7 && neg) nib = 4'h0;
         else if (nib > 4'd9) bad = 1'b1;
         mag = mag * 10 + longint'(nib);
      end
      if (bad) return {1'b1, 32'h0};
      v = 32'(mag);
      if (neg) v = -v;
      return {1'b0, v};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model update at each rising edge from the bench-driven inputs.
   always @(posedge clk) begin
      logic [32:0] r;
      cyc++;
      if (rst) begin
         m_valid = 1'b1;
         m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_bin = 32'h0; m_radix = 5'd0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_done = 1'b1; m_busy = 1'b0; m_bin = p_bin; m_err = p_err;
            end
         end else if (start && (cs10 ^ cs16)) begin
            r = ref_conv(digits_in, cs10);
            p_err = r[32]; p_bin = r[31:0];
            m_cnt = 9; m_busy = 1'b1;
            m_radix = cs10 ? 5'd10 : 5'd16;
         end else begin
            m_radix = 5'd0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("bin_out", bin_out, m_bin);
         chk("err", 32'(err), 32'(m_err));
         chk("radix", 32'(radix), 32'(m_radix));
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("done_timeout", 32'(n), 32'd9);
   endtask

   task automatic conv(input string nm, input logic s10, input logic s16,
                       input logic [31:0] dig, input logic [31:0] eb, input logic ee);
      int n;
      @(negedge clk); #2;
      start = 1'b1; cs10 = s10; cs16 = s16; digits_in = dig;
      @(negedge clk); #2;
      start = 1'b0; cs10 = 1'($urandom); cs16 = 1'($urandom); digits_in = $urandom;
      wait_done(n);
      chk({nm, "_latency"}, 32'(n), 32'd9);
      chk({nm, "_bin"}, bin_out, eb);
      chk({nm, "_err"}, 32'(err), 32'(ee));
      chk({nm, "_radix"}, 32'(radix), s10 ? 32'd10 : 32'd16);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dn, t1, t2, mode, hold, k;
      logic [31:0] d;

      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bin", bin_out, 32'h0);
      chk("rst_radix", 32'(radix), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      conv("hex", 1'b0, 1'b1, 32'h1234ABCD, 32'h1234ABCD, 1'b0);
      conv("dec1234", 1'b1, 1'b0, 32'h00001234, 32'h000004D2, 1'b0);
      conv("decmax", 1'b1, 1'b0, 32'h99999999, 32'h05F5E0FF, 1'b0);
      conv("neg42", 1'b1, 1'b0, 32'hF0000042, 32'hFFFFFFD6, 1'b0);
      conv("bad1A", 1'b1, 1'b0, 32'h0000001A, 32'h0, 1'b1);
      conv("badtop", 1'b1, 1'b0, 32'hB0000001, 32'h0, 1'b1);
      conv("negzero", 1'b1, 1'b0, 32'hF0000000, 32'h0, 1'b0);
      conv("neg7max", 1'b1, 1'b0, 32'hF9999999, 32'hFF676981, 1'b0);

      // reset in the middle of a conversion
      @(negedge clk); #2;
      start = 1'b1; cs10 = 1'b1; cs16 = 1'b0; digits_in = 32'h00001234;
      @(negedge clk); #2 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_bin", bin_out, 32'h0);
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("midrst_no_done", 32'(dn), 32'd0);

      // illegal select combinations are ignored
      #2 start = 1'b1; cs10 = 1'b1; cs16 = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("both_sel_busy", 32'(busy), 32'd0);
      end
      #2 cs10 = 1'b0; cs16 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_sel_busy", 32'(busy), 32'd0);
      end

      // start held high: back-to-back conversions, digits changed mid-flight
      #2 start = 1'b1; cs16 = 1'b1; digits_in = 32'h00000001;
      @(negedge clk); #2 digits_in = 32'h00000002;
      wait_done(n);
      t1 = cyc;
      chk("b2b_first", bin_out, 32'h00000001);
      @(negedge clk); #2 start = 1'b0; digits_in = 32'hDEADBEEF;
      wait_done(n);
      t2 = cyc;
      chk("b2b_second", bin_out, 32'h00000002);
      chk("b2b_spacing", 32'(t2 - t1), 32'd10);

      // randomized traffic checked by the model
      for (k = 0; k < 150; k++) begin
         mode = $urandom_range(0, 3);
         d = $urandom;
         if (mode == 0 && $urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 8; i++) d[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) d[31:28] = 4'hF;
         end
         hold = $urandom_range(1, 2);
         @(negedge clk); #2;
         start = 1'b1; digits_in = d;
         cs10 = (mode == 0 || mode == 2);
         cs16 = (mode == 1 || mode == 2);
         repeat (hold) @(negedge clk);
         #2 start = 1'b0;
         n = 0;
         while (n < 30) begin
            if ($urandom_range(0, 1) == 1) digits_in = $urandom;
            cs10 = 1'($urandom); cs16 = 1'($urandom);
            @(negedge clk); #2;
            if (m_cnt == 0 && !busy) break;
            n++;
         end
         if (n >= 30) chk("rand_idle_timeout", 32'(n), 32'd0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
